// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU classes, funct codes,
// FSM state type, EX/MEM register layout and the default multiply length.
package ex_stage_pkg;

  localparam int MUL_CYCLES = 32;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h18;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} exState_e;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [31:0] branchTarget;
    logic [4:0]  writeReg;
    logic        zero;
    logic        hit;
    logic        memtoReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
  } exMem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one bus.
// Handshake: hit is a per-cycle advance strobe; while busy=1 the stage ignores hit and upstream must hold.
interface ex_stage_if;
  logic        hit;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] signExImmediate;
  logic [31:0] nextPC;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [2:0]  ALUOp;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;

  logic [31:0] aluResultOut;
  logic [31:0] writeDataOut;
  logic [31:0] branchTargetOut;
  logic [4:0]  writeRegOut;
  logic        zeroOut;
  logic        hitOut;
  logic        MemtoRegOut;
  logic        RegWriteOut;
  logic        MemReadOut;
  logic        MemWriteOut;
  logic        BranchOut;
  logic        busy;

  modport master (
    output hit, readData1, readData2, signExImmediate, nextPC, RegDst, ALUSrc,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, rt, rd, funct,
    input  aluResultOut, writeDataOut, branchTargetOut, writeRegOut, zeroOut, hitOut,
           MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut, busy
  );

  modport slave (
    input  hit, readData1, readData2, signExImmediate, nextPC, RegDst, ALUSrc,
           MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, rt, rd, funct,
    output aluResultOut, writeDataOut, branchTargetOut, writeRegOut, zeroOut, hitOut,
           MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut, busy
  );
endinterface

// File: rtl/ex_stage_seq_mul.sv
// Iterative shift-add multiplier returning the low W bits of a*b.
// start loads operands; done is high during the final iteration with product valid.
module seq_mul #(
  parameter int MUL_CYCLES = 32,
  parameter int W          = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic          running;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplr;
  logic [W-1:0]  accNext;

  always_comb begin
    accNext = acc + (mplr[0] ? mcand : '0);
    done    = running && (cnt == CW'(MUL_CYCLES - 1));
    product = accNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= a;
      mplr    <= b;
    end else if (running) begin
      acc   <= accNext;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand mux, single-cycle ALU, branch target, and the EX/MEM
// register; multiplies park the fields and wait on seq_mul while busy.
module ex_stage #(
  parameter int MUL_CYCLES = ex_stage_pkg::MUL_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ex_stage_if.slave              bus,
  output ex_stage_pkg::exState_e stateDbg
);
  import ex_stage_pkg::*;

  exState_e    state, stateNext;
  logic [31:0] opB;
  logic [31:0] aluRes;
  logic        isMul;
  logic        mulStart;
  logic        mulDone;
  logic [31:0] mulProduct;
  exMem_t      cur, held, outReg, outNext;

  always_comb begin
    opB    = bus.ALUSrc ? bus.signExImmediate : bus.readData2;
    aluRes = '0;
    isMul  = 1'b0;
    case (bus.ALUOp)
      ALU_ADD: aluRes = bus.readData1 + opB;
      ALU_SUB: aluRes = bus.readData1 - opB;
      ALU_AND: aluRes = bus.readData1 & opB;
      ALU_OR:  aluRes = bus.readData1 | opB;
      ALU_SLT: aluRes = {31'd0, $signed(bus.readData1) < $signed(opB)};
      ALU_FUNCT: begin
        case (bus.funct)
          FN_ADD:  aluRes = bus.readData1 + opB;
          FN_SUB:  aluRes = bus.readData1 - opB;
          FN_AND:  aluRes = bus.readData1 & opB;
          FN_OR:   aluRes = bus.readData1 | opB;
          FN_SLT:  aluRes = {31'd0, $signed(bus.readData1) < $signed(opB)};
          FN_MUL:  isMul  = 1'b1;
          default: aluRes = '0;
        endcase
      end
      default: aluRes = bus.readData1 + opB;
    endcase
  end

  always_comb begin
    cur.aluResult    = aluRes;
    cur.writeData    = bus.readData2;
    cur.branchTarget = bus.nextPC + (bus.signExImmediate << 2);
    cur.writeReg     = bus.RegDst ? bus.rd : bus.rt;
    cur.zero         = (aluRes == 32'd0);
    cur.hit          = 1'b1;
    cur.memtoReg     = bus.MemtoReg;
    cur.regWrite     = bus.RegWrite;
    cur.memRead      = bus.MemRead;
    cur.memWrite     = bus.MemWrite;
    cur.branch       = bus.Branch;
  end

  // The completing edge returns to IDLE without looking at hit, so no
  // instruction can slip in alongside the multiply result.
  always_comb begin
    stateNext = state;
    mulStart  = 1'b0;
    outNext   = outReg;
    case (state)
      IDLE: begin
        if (bus.hit) begin
          if (isMul) begin
            mulStart  = 1'b1;
            stateNext = MUL;
          end else begin
            outNext = cur;
          end
        end
      end
      MUL: begin
        if (mulDone) begin
          outNext           = held;
          outNext.aluResult = mulProduct;
          outNext.zero      = (mulProduct == 32'd0);
          stateNext         = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      outReg <= '0;
      held   <= '0;
    end else begin
      state  <= stateNext;
      outReg <= outNext;
      if (mulStart) held <= cur;
    end
  end

  seq_mul #(.MUL_CYCLES(MUL_CYCLES), .W(32)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mulStart),
    .a       (bus.readData1),
    .b       (opB),
    .done    (mulDone),
    .product (mulProduct)
  );

  assign bus.aluResultOut    = outReg.aluResult;
  assign bus.writeDataOut    = outReg.writeData;
  assign bus.branchTargetOut = outReg.branchTarget;
  assign bus.writeRegOut     = outReg.writeReg;
  assign bus.zeroOut         = outReg.zero;
  assign bus.hitOut          = outReg.hit;
  assign bus.MemtoRegOut     = outReg.memtoReg;
  assign bus.RegWriteOut     = outReg.regWrite;
  assign bus.MemReadOut      = outReg.memRead;
  assign bus.MemWriteOut     = outReg.memWrite;
  assign bus.BranchOut       = outReg.branch;
  assign bus.busy            = (state == MUL);
  assign stateDbg            = state;
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: MUL_CYCLES, default 32, number of shift-add iterations per multiply; fixed at 32 for 32-bit operands.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 hit  in  1  pipeline advance enable from the ID/EX register; 1 = capture, 0 = hold.
REQ-005 readData1, readData2, signExImmediate, nextPC  in  32 each  operands, immediate and PC+4 from ID/EX.
REQ-006 RegDst, ALUSrc  in  1 each  EX-local controls, consumed here.
REQ-007 MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  controls forwarded to EX/MEM.
REQ-008 ALUOp  in  3  ALU class; rt, rd  in  5 each; funct  in  6.
REQ-009 aluResultOut, writeDataOut, branchTargetOut  out  32 each  registered EX/MEM fields.
REQ-010 writeRegOut  out  5; zeroOut  out  1; hitOut  out  1  registered copy of accepted hit.
REQ-011 MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut  out  1 each  registered controls.
REQ-012 busy  out  1  multiply in progress; upstream SHALL stall while 1.

Function
REQ-013 Operand B SHALL be signExImmediate when ALUSrc=1, else readData2.
REQ-014 ALUOp 000 add, 001 sub, 011 and, 100 or, 101 signed slt, 010 decode funct, 110/111 add.
REQ-015 funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x18 multiply (low 32 bits), any other result 0.
REQ-016 Add/sub/multiply SHALL wrap modulo 2^32; no overflow flag or exception.
REQ-017 branchTarget SHALL be nextPC + (signExImmediate << 2) modulo 2^32.
REQ-018 writeReg SHALL be rd when RegDst=1, else rt; writeData SHALL be readData2.
REQ-019 zero SHALL be 1 exactly when the ALU result equals 0.
REQ-020 FSM states IDLE, MUL.
REQ-021 IDLE, hit=1, non-multiply: all EX/MEM outputs capture at the edge; latency 1 cycle.
REQ-022 IDLE, hit=0: all outputs hold, including hitOut.
REQ-023 IDLE, hit=1, ALUOp=010, funct=0x18: latch operands and all pass-through fields; go to MUL; cnt=0; busy=1; outputs hold.
REQ-024 MUL: one shift-add iteration per edge, cnt increments; hit and data inputs ignored.
REQ-025 MUL with cnt=MUL_CYCLES-1: final iteration; outputs capture the product and latched fields; hitOut=1; return to IDLE; busy=0.
REQ-026 Multiply latency: result visible after the 32nd edge following the accepting edge; busy high for exactly 32 cycles.
REQ-027 A new instruction SHALL NOT be accepted on the edge that completes a multiply.
REQ-028 Back-to-back multiplies: the second starts only on the first IDLE edge with hit=1.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, cnt=0, busy=0, and every output to 0.
REQ-030 Reset during MUL SHALL abandon the multiply; no partial result appears after release.
REQ-031 The first capture after reset release SHALL require hit=1.

Structure
REQ-032 A shared package SHALL hold the ALUOp encodings, funct codes, FSM state type and MUL_CYCLES.
REQ-033 The multiplier SHALL be one sub-module, seq_mul, with start/done handshake; ALU, muxes and register SHALL stay in ex_stage.

Verification
REQ-034 Add: rd1=5, imm=23, ALUSrc=1, ALUOp=000, hit=1 -> aluResultOut=28, zeroOut=0 after one edge.
REQ-035 Branch: rd1=7, rd2=7, ALUOp=001, nextPC=0x100, imm=4 -> zeroOut=1, branchTargetOut=0x110.
REQ-036 Hold: hit=0 with changed inputs -> all outputs unchanged; hit=1 -> capture next edge.
REQ-037 Multiply: rd1=0xFFFFFFFF, rd2=3, funct=0x18 -> busy 32 cycles, aluResultOut=0xFFFFFFFD, then busy=0.
REQ-038 Reset mid-multiply at cycle 10 -> busy=0 and outputs 0 immediately; no result later.
REQ-039 R-type slt: rd1=0xFFFFFFFE, rd2=1, RegDst=1, rd=9 -> aluResultOut=1, writeRegOut=9.
